// File: rtl/imm_enc.sv
// imm_enc: finds a 16-bit imm + EOp reproducing a 32-bit constant, else a lui/ori split.
// Define IMM_ENC_VERIFY_EN to add a VERIFY state that re-expands the result and sets err.
module imm_enc (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  output logic        ready,
  output logic        done,
  output logic        fit,
  output logic [1:0]  eop,
  output logic [15:0] imm,
  output logic [15:0] hi,
  output logic [15:0] lo,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, CHK0, CHK1, CHK2, CHK3, VERIFY, DONE
  } state_t;

`ifdef IMM_ENC_VERIFY_EN
  localparam state_t FIN = VERIFY;
`else
  localparam state_t FIN = DONE;
`endif

  state_t      state, nstate;
  logic [31:0] v;
  logic        ld;
  logic        n_fit;
  logic [1:0]  n_eop;
  logic [15:0] n_imm, n_hi, n_lo;

  logic z0, s1, l2, s3;
  assign z0 = (v[31:16] == '0);
  assign s1 = (v[31:15] == '0) || (v[31:15] == '1);
  assign l2 = (v[15:0] == '0);
  assign s3 = (v[1:0] == '0) &&
              ((v[31:17] == '0) || (v[31:17] == '1));

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  always_comb begin
    nstate = state;
    ld     = 1'b0;
    n_fit  = 1'b1;
    n_eop  = 2'b00;
    n_imm  = v[15:0];
    n_hi   = '0;
    n_lo   = '0;
    unique case (state)
      IDLE: if (start) nstate = CHK0;
      CHK0: begin
        nstate = CHK1;
        if (z0) begin
          ld     = 1'b1;
          nstate = FIN;
        end
      end
      CHK1: begin
        nstate = CHK2;
        n_eop  = 2'b01;
        if (s1) begin
          ld     = 1'b1;
          nstate = FIN;
        end
      end
      CHK2: begin
        nstate = CHK3;
        n_eop  = 2'b10;
        n_imm  = v[31:16];
        if (l2) begin
          ld     = 1'b1;
          nstate = FIN;
        end
      end
      CHK3: begin
        ld     = 1'b1;
        nstate = FIN;
        if (s3) begin
          n_eop = 2'b11;
          n_imm = v[17:2];
        end else begin
          // no single mode fits: lui hi / ori lo
          n_fit = 1'b0;
          n_eop = 2'b10;
          n_imm = v[31:16];
          n_hi  = v[31:16];
          n_lo  = v[15:0];
        end
      end
      VERIFY:  nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      v     <= '0;
      fit   <= 1'b0;
      eop   <= 2'b00;
      imm   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= nstate;
      if (state == IDLE && start) v <= value;
      if (ld) begin
        fit <= n_fit;
        eop <= n_eop;
        imm <= n_imm;
        hi  <= n_hi;
        lo  <= n_lo;
      end
    end
  end

`ifdef IMM_ENC_VERIFY_EN
  function automatic logic [31:0] ext(
    input logic [15:0] i,
    input logic [1:0]  op
  );
    logic [31:0] r;
    unique case (op)
      2'b00:   r = {16'h0, i};
      2'b01:   r = {{16{i[15]}}, i};
      2'b10:   r = {i, 16'h0};
      default: r = {{14{i[15]}}, i, 2'b00};
    endcase
    return r;
  endfunction

  logic [31:0] rebuilt;
  logic        err_q;
  assign rebuilt = fit ? ext(imm, eop) : {hi, lo};
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else if (state == VERIFY) err_q <= (rebuilt != v);
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imm_enc.sv
// tb_imm_enc: table-driven check of imm_enc plus handshake/reset sequences.
// Expected values are hand-derived from the EOp definitions.
module tb_imm_enc;

`ifdef IMM_ENC_VERIFY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] value;
  logic        ready, done, fit, err;
  logic [1:0]  eop;
  logic [15:0] imm, hi, lo;

  int nchk = 0;
  int nfail = 0;

  imm_enc dut (
    .clk(clk), .reset(reset), .start(start), .value(value),
    .ready(ready), .done(done), .fit(fit), .eop(eop),
    .imm(imm), .hi(hi), .lo(lo), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    int          lat;
    logic        fit;
    logic [1:0]  eop;
    logic [15:0] imm;
    logic [15:0] hi;
    logic [15:0] lo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // waits at negedges for done; returns cycle number after edge 0, or -1
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) n = -1;
  endtask

  task automatic launch(input logic [31:0] v, output int n);
    @(negedge clk);
    value = v;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    value = 32'hDEAD_BEEF;
    wait_done(1, n);
  endtask

  vec_t vt[15];
  int   n;
  logic [15:0] imm_s;

  initial begin
    vt[0]  = '{32'h0000_1234, 2, 1'b1, 2'b00, 16'h1234, 16'h0, 16'h0};
    vt[1]  = '{32'hFFFF_8000, 3, 1'b1, 2'b01, 16'h8000, 16'h0, 16'h0};
    vt[2]  = '{32'h1234_0000, 4, 1'b1, 2'b10, 16'h1234, 16'h0, 16'h0};
    vt[3]  = '{32'h0002_0000, 4, 1'b1, 2'b10, 16'h0002, 16'h0, 16'h0};
    vt[4]  = '{32'hFFFE_0004, 5, 1'b1, 2'b11, 16'h8001, 16'h0, 16'h0};
    vt[5]  = '{32'h1234_5678, 5, 1'b0, 2'b10, 16'h1234, 16'h1234, 16'h5678};
    vt[6]  = '{32'h0000_0000, 2, 1'b1, 2'b00, 16'h0000, 16'h0, 16'h0};
    vt[7]  = '{32'hFFFF_FFFF, 3, 1'b1, 2'b01, 16'hFFFF, 16'h0, 16'h0};
    vt[8]  = '{32'h0000_8000, 2, 1'b1, 2'b00, 16'h8000, 16'h0, 16'h0};
    vt[9]  = '{32'h0001_0000, 4, 1'b1, 2'b10, 16'h0001, 16'h0, 16'h0};
    vt[10] = '{32'hFFFF_0000, 4, 1'b1, 2'b10, 16'hFFFF, 16'h0, 16'h0};
    vt[11] = '{32'h0002_0002, 5, 1'b0, 2'b10, 16'h0002, 16'h0002, 16'h0002};
    vt[12] = '{32'h0001_FFFC, 5, 1'b1, 2'b11, 16'h7FFF, 16'h0, 16'h0};
    vt[13] = '{32'hFFFF_7FFF, 5, 1'b0, 2'b10, 16'hFFFF, 16'hFFFF, 16'h7FFF};
    vt[14] = '{32'h0000_0002, 2, 1'b1, 2'b00, 16'h0002, 16'h0, 16'h0};

    reset = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_out", {fit, eop, imm, hi, lo, err}, '0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      launch(vt[i].v, n);
      check($sformatf("lat[%0d]", i), n, vt[i].lat + EXTRA);
      check($sformatf("fit[%0d]", i), {31'b0, fit}, {31'b0, vt[i].fit});
      check($sformatf("eop[%0d]", i), {30'b0, eop}, {30'b0, vt[i].eop});
      check($sformatf("imm[%0d]", i), {16'b0, imm}, {16'b0, vt[i].imm});
      check($sformatf("hi[%0d]", i), {16'b0, hi}, {16'b0, vt[i].hi});
      check($sformatf("lo[%0d]", i), {16'b0, lo}, {16'b0, vt[i].lo});
      check($sformatf("err[%0d]", i), {31'b0, err}, 32'd0);
      check($sformatf("rdy_dn[%0d]", i), {31'b0, ready}, 32'd0);
      @(negedge clk);
      check($sformatf("pulse[%0d]", i), {31'b0, done}, 32'd0);
      check($sformatf("idle[%0d]", i), {31'b0, ready}, 32'd1);
      @(negedge clk);
      check($sformatf("hold[%0d]", i), {16'b0, imm}, {16'b0, vt[i].imm});
    end

    // start/value churn while busy; start held high through DONE
    value = 32'h1234_5678;
    start = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done) begin
        start = n[0];
        value = $urandom;
      end
    end while (!done && n < 20);
    check("churn_lat", n, 5 + EXTRA);
    check("churn_fit", {31'b0, fit}, 32'd0);
    check("churn_hilo", {hi, lo}, 32'h1234_5678);
    start = 1'b1;
    value = 32'h0000_1234;
    @(negedge clk);
    check("done_start_ign", {31'b0, ready}, 32'd1);
    check("done_start_dn", {31'b0, done}, 32'd0);
    @(negedge clk);
    check("acc_after", {31'b0, ready}, 32'd0);
    start = 1'b0;
    value = 32'hFFFF_FFFF;
    wait_done(1, n);
    check("next_lat", n, 2 + EXTRA);
    check("next_res", {fit, eop, imm}, {1'b1, 2'b00, 16'h1234});

    // reset asserted while in CHK2 cancels the run
    launch(32'h1234_5678, n);
    @(negedge clk);
    value = 32'h1234_5678;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", {31'b0, ready}, 32'd1);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_out", {fit, eop, imm, hi, lo, err}, '0);
    reset = 1'b0;
    imm_s = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) imm_s = 16'hFFFF;
    end
    check("mid_rst_nodone", {16'b0, imm_s}, 32'd0);
    check("mid_rst_ready2", {31'b0, ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
